// File: rtl/fetch_queue_unit_if.sv
// Fetch front-end bundle: instruction-memory request/response, redirect, and IF/ID handshake.
interface fetch_queue_unit_if #(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned INS_W = 32,
    parameter int unsigned OCC_W = 3
);
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_rvalid;
    logic [INS_W-1:0] imem_rdata;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic             if_valid;
    logic [INS_W-1:0] if_instr;
    logic [PC_W-1:0]  if_pc;
    logic             if_ready;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc, occupancy,
        input  imem_rvalid, imem_rdata, redirect, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, occupancy,
        output imem_rvalid, imem_rdata, redirect, redirect_pc, if_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: in-order requests to variable-latency imem, credit-limited
// FIFO of {instr, pc} toward IF/ID, redirect flush with stale-response dropping.
module fetch_queue_unit #(
    parameter int unsigned    PC_W      = 9,
    parameter int unsigned    INS_W     = 32,
    parameter int unsigned    DEPTH     = 4,
    parameter int unsigned    MAX_OUTST = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned    PC_STEP   = 4
) (
    input  logic               clk,
    input  logic               reset,
    fetch_queue_unit_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(MAX_OUTST + 1);
    localparam int unsigned UW = AW + CW + 1;
    localparam logic [PC_W-1:0] STEP  = PC_W'(PC_STEP);
    localparam logic [AW:0]     P_ONE = (AW + 1)'(1);
    localparam logic [CW-1:0]   C_ONE = CW'(1);

    logic [PC_W-1:0]  r_fetch_pc;
    logic [PC_W-1:0]  r_resp_pc;
    logic [CW-1:0]    r_outst;
    logic [CW-1:0]    r_drop;
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [INS_W-1:0] r_q_instr [DEPTH];
    logic [PC_W-1:0]  r_q_pc    [DEPTH];

    logic [AW:0]      w_occ;
    logic             w_empty;
    logic             w_full;
    logic [UW-1:0]    w_used;
    logic             w_issue;
    logic             w_rsp;
    logic             w_rsp_keep;
    logic             w_deq;
    logic [AW-1:0]    w_widx;
    logic [AW-1:0]    w_ridx;

    assign w_occ   = r_wptr - r_rptr;
    assign w_empty = (w_occ == '0);
    assign w_full  = (w_occ == (AW + 1)'(DEPTH));
    assign w_widx  = r_wptr[AW-1:0];
    assign w_ridx  = r_rptr[AW-1:0];

    // Stale in-flight requests will not land in the queue, so they hold no credit.
    assign w_used  = UW'(w_occ) + UW'(r_outst) - UW'(r_drop);
    assign w_issue = reset && !bus.redirect && (r_outst < CW'(MAX_OUTST)) && (w_used < UW'(DEPTH));

    // A response with nothing outstanding (e.g. left over from before reset) is ignored.
    assign w_rsp      = bus.imem_rvalid && (r_outst != '0);
    assign w_rsp_keep = w_rsp && (r_drop == '0) && !bus.redirect;
    assign w_deq      = !w_empty && bus.if_ready && !bus.redirect;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_outst    <= '0;
            r_drop     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_outst <= r_outst + CW'(w_issue) - CW'(w_rsp);
            if (bus.redirect) begin
                r_fetch_pc <= bus.redirect_pc;
                r_resp_pc  <= bus.redirect_pc;
                r_wptr     <= '0;
                r_rptr     <= '0;
                // Already-stale requests are counted in r_outst, so after a flush every
                // request still in flight is stale: that is exactly outst minus this response.
                r_drop     <= r_outst - CW'(w_rsp);
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + STEP;
                end
                if (w_rsp && (r_drop != '0)) begin
                    r_drop <= r_drop - C_ONE;
                end
                if (w_rsp_keep) begin
                    r_wptr    <= r_wptr + P_ONE;
                    r_resp_pc <= r_resp_pc + STEP;
                end
                if (w_deq) begin
                    r_rptr <= r_rptr + P_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_rsp_keep) begin
            r_q_instr[w_widx] <= bus.imem_rdata;
            r_q_pc[w_widx]    <= r_resp_pc;
        end
    end

    assign bus.imem_req  = w_issue;
    assign bus.imem_addr = r_fetch_pc;
    assign bus.if_valid  = !w_empty;
    assign bus.if_instr  = w_empty ? '0 : r_q_instr[w_ridx];
    assign bus.if_pc     = w_empty ? '0 : r_q_pc[w_ridx];
    assign bus.occupancy = w_occ;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(w_rsp_keep && w_full && !w_deq));
endmodule
